// File: rtl/fc_layer_sequencer_if.sv
// Handshake and SRAM/MAC control bundle between the layer FSM, the FC
// sequencer and the FC datapath.
interface fc_layer_sequencer_if #(
  parameter int unsigned DATA_ADDR_WIDTH   = 10,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 15
);
  logic                         start;
  logic [DATA_ADDR_WIDTH-1:0]   in_base;
  logic [WEIGHT_ADDR_WIDTH-1:0] weight_base;
  logic                         busy;
  logic [DATA_ADDR_WIDTH-1:0]   sram_raddr_in;
  logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight;
  logic                         acc_clear;
  logic                         acc_en;
  logic                         out_wen;
  logic [DATA_ADDR_WIDTH-1:0]   sram_waddr;
  logic [3:0]                   sram_bytemask;
  logic                         done;

  modport master (
    output start, in_base, weight_base,
    input  busy, sram_raddr_in, sram_raddr_weight, acc_clear, acc_en,
           out_wen, sram_waddr, sram_bytemask, done
  );

  modport slave (
    input  start, in_base, weight_base,
    output busy, sram_raddr_in, sram_raddr_weight, acc_clear, acc_en,
           out_wen, sram_waddr, sram_bytemask, done
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Fully connected layer sequencer: walks (neuron, word) pairs, issues SRAM
// read addresses, drives MAC strobes and writes finished neurons by byte lane.
module fc_layer_sequencer #(
  parameter int unsigned IN_WORDS          = 25,
  parameter int unsigned OUT_NUM           = 20,
  parameter int unsigned DATA_ADDR_WIDTH   = 10,
  parameter int unsigned WEIGHT_ADDR_WIDTH = 15
) (
  input  logic                 clk,
  input  logic                 srst,
  fc_layer_sequencer_if.slave  bus
);
  localparam int unsigned KW = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
  localparam int unsigned NW = (OUT_NUM > 4) ? $clog2(OUT_NUM) : 2;
  localparam logic [KW-1:0] K_LAST = KW'(IN_WORDS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(OUT_NUM - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                       state_q, state_d;
  logic [KW-1:0]                k_q, k_d;
  logic [NW-1:0]                n_q, n_d;
  logic                         drain_q, drain_d;
  logic [DATA_ADDR_WIDTH-1:0]   in_base_q, in_base_d;
  logic [DATA_ADDR_WIDTH-1:0]   raddr_in_q, raddr_in_d;
  logic [WEIGHT_ADDR_WIDTH-1:0] raddr_w_q, raddr_w_d;
  logic                         acc_en_q, acc_en_d;
  logic                         acc_clear_q, acc_clear_d;
  logic                         last_q, last_d;
  logic [NW-1:0]                pn_q, pn_d;
  logic                         wen_q, wen_d;
  logic [DATA_ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [3:0]                   mask_q, mask_d;

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    drain_d    = drain_q;
    in_base_d  = in_base_q;
    raddr_in_d = raddr_in_q;
    raddr_w_d  = raddr_w_q;

    // Issue flags are delayed one cycle to line up with SRAM read data.
    acc_en_d    = (state_q == RUN);
    acc_clear_d = (state_q == RUN) && (k_q == '0);
    last_d      = (state_q == RUN) && (k_q == K_LAST);
    pn_d        = (state_q == RUN) ? n_q : pn_q;

    wen_d   = acc_en_q && last_q;
    waddr_d = waddr_q;
    mask_d  = mask_q;
    if (acc_en_q && last_q) begin
      waddr_d = DATA_ADDR_WIDTH'(pn_q >> 2);
      mask_d  = ~(4'b1000 >> pn_q[1:0]);
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          in_base_d  = bus.in_base;
          raddr_in_d = bus.in_base;
          raddr_w_d  = bus.weight_base;
          k_d        = '0;
          n_d        = '0;
        end
      end
      RUN: begin
        // The final issue leaves the addresses untouched so they hold outside RUN.
        if (k_q == K_LAST) begin
          k_d = '0;
          if (n_q == N_LAST) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            n_d        = n_q + NW'(1);
            raddr_in_d = in_base_q;
            raddr_w_d  = raddr_w_q + WEIGHT_ADDR_WIDTH'(1);
          end
        end else begin
          k_d        = k_q + KW'(1);
          raddr_in_d = in_base_q + DATA_ADDR_WIDTH'(k_d);
          raddr_w_d  = raddr_w_q + WEIGHT_ADDR_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = DONE;
        else         drain_d = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      n_q         <= '0;
      drain_q     <= 1'b0;
      in_base_q   <= '0;
      raddr_in_q  <= '0;
      raddr_w_q   <= '0;
      acc_en_q    <= 1'b0;
      acc_clear_q <= 1'b0;
      last_q      <= 1'b0;
      pn_q        <= '0;
      wen_q       <= 1'b0;
      waddr_q     <= '0;
      mask_q      <= '1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      drain_q     <= drain_d;
      in_base_q   <= in_base_d;
      raddr_in_q  <= raddr_in_d;
      raddr_w_q   <= raddr_w_d;
      acc_en_q    <= acc_en_d;
      acc_clear_q <= acc_clear_d;
      last_q      <= last_d;
      pn_q        <= pn_d;
      wen_q       <= wen_d;
      waddr_q     <= waddr_d;
      mask_q      <= mask_d;
    end
  end

  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = (state_q == DONE);
  assign bus.sram_raddr_in     = raddr_in_q;
  assign bus.sram_raddr_weight = raddr_w_q;
  assign bus.acc_en            = acc_en_q;
  assign bus.acc_clear         = acc_clear_q;
  assign bus.out_wen           = wen_q;
  assign bus.sram_waddr        = waddr_q;
  assign bus.sram_bytemask     = mask_q;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: two configurations checked every cycle against
// a cycle-index model of the layer timing, plus directed literal expectations.
module tb_fc_layer_sequencer;
  localparam int DAW = 10;
  localparam int WAW = 15;
  localparam int IW0 = 2;
  localparam int ON0 = 6;
  localparam int IW1 = 1;
  localparam int ON1 = 4;

  logic clk = 1'b0;
  logic srst;
  always #5 clk = ~clk;

  fc_layer_sequencer_if #(.DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW)) b0 ();
  fc_layer_sequencer_if #(.DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW)) b1 ();

  fc_layer_sequencer #(.IN_WORDS(IW0), .OUT_NUM(ON0),
                       .DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW))
    dut0 (.clk(clk), .srst(srst), .bus(b0));
  fc_layer_sequencer #(.IN_WORDS(IW1), .OUT_NUM(ON1),
                       .DATA_ADDR_WIDTH(DAW), .WEIGHT_ADDR_WIDTH(WAW))
    dut1 (.clk(clk), .srst(srst), .bus(b1));

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL d%0d %s got %0h expected %0h at %0t", inst, nm, act, exp, $time);
  endtask

  // Model: run state is just "cycle index t since the accepted start".
  int iw [2] = '{IW0, IW1};
  int on [2] = '{ON0, ON1};
  bit m_act [2];
  int m_t   [2];
  int m_ib  [2];
  int m_wb  [2];
  int e_in [2], e_w [2], e_waddr [2], e_mask [2];
  bit e_busy [2], e_acc [2], e_clr [2], e_wen [2], e_done [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic int  n  = iw[i] * on[i];
      automatic bit  st = (i == 0) ? b0.start : b1.start;
      automatic int  ib = (i == 0) ? int'(b0.in_base) : int'(b1.in_base);
      automatic int  wb = (i == 0) ? int'(b0.weight_base) : int'(b1.weight_base);
      automatic int  t;
      if (srst) begin
        m_act[i] = 1'b0; m_t[i] = 0;
        e_in[i] = 0; e_w[i] = 0; e_waddr[i] = 0; e_mask[i] = 'hF;
      end else if (m_act[i]) begin
        if (m_t[i] == n + 3) m_act[i] = 1'b0;
        else m_t[i]++;
      end else if (st) begin
        m_act[i] = 1'b1; m_t[i] = 1; m_ib[i] = ib; m_wb[i] = wb;
      end
      t = m_t[i];
      e_busy[i] = m_act[i];
      if (m_act[i] && t <= n) begin
        e_in[i] = (m_ib[i] + (t - 1) % iw[i]) % (1 << DAW);
        e_w[i]  = (m_wb[i] + t - 1) % (1 << WAW);
      end
      e_acc[i]  = m_act[i] && t >= 2 && t <= n + 1;
      e_clr[i]  = e_acc[i] && ((t - 2) % iw[i] == 0);
      e_wen[i]  = m_act[i] && t >= iw[i] + 2 && t <= n + 2 && ((t - 2) % iw[i] == 0);
      if (e_wen[i]) begin
        automatic int j = (t - 2) / iw[i] - 1;
        e_waddr[i] = j / 4;
        e_mask[i]  = 'hF & ~('h8 >> (j % 4));
      end
      e_done[i] = m_act[i] && t == n + 3;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk("busy",   i, (i == 0) ? int'(b0.busy) : int'(b1.busy), int'(e_busy[i]));
        chk("raddr_in", i, (i == 0) ? int'(b0.sram_raddr_in) : int'(b1.sram_raddr_in), e_in[i]);
        chk("raddr_w", i, (i == 0) ? int'(b0.sram_raddr_weight) : int'(b1.sram_raddr_weight), e_w[i]);
        chk("acc_en", i, (i == 0) ? int'(b0.acc_en) : int'(b1.acc_en), int'(e_acc[i]));
        chk("acc_clear", i, (i == 0) ? int'(b0.acc_clear) : int'(b1.acc_clear), int'(e_clr[i]));
        chk("out_wen", i, (i == 0) ? int'(b0.out_wen) : int'(b1.out_wen), int'(e_wen[i]));
        chk("waddr",  i, (i == 0) ? int'(b0.sram_waddr) : int'(b1.sram_waddr), e_waddr[i]);
        chk("bytemask", i, (i == 0) ? int'(b0.sram_bytemask) : int'(b1.sram_bytemask), e_mask[i]);
        chk("done",   i, (i == 0) ? int'(b0.done) : int'(b1.done), int'(e_done[i]));
      end
    end
  end

  // Starts both instances at the next edge (edge 0) and pins cycles 1..16 to
  // hand-derived values; also pulses start while busy and in d0's DONE cycle.
  task automatic directed_run(input int ib, input int wb);
    int rin [6] = '{0, 1, 0, 1, 0, 1};
    int mtab [6] = '{'h7, 'hB, 'hD, 'hE, 'h7, 'hB};
    int wtab [6] = '{0, 0, 0, 0, 1, 1};
    int w = 0;
    b0.start = 1'b1; b1.start = 1'b1;
    b0.in_base = DAW'(ib); b1.in_base = DAW'(ib);
    b0.weight_base = WAW'(wb); b1.weight_base = WAW'(wb);
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      chk("lit_busy", 0, int'(b0.busy), int'(c <= 15));
      chk("lit_done", 0, int'(b0.done), int'(c == 15));
      chk("lit_acc_en", 0, int'(b0.acc_en), int'(c >= 2 && c <= 13));
      chk("lit_acc_clear", 0, int'(b0.acc_clear), int'(c inside {2, 4, 6, 8, 10, 12}));
      chk("lit_out_wen", 0, int'(b0.out_wen), int'(c inside {4, 6, 8, 10, 12, 14}));
      if (c inside {4, 6, 8, 10, 12, 14}) begin
        chk("lit_waddr", 0, int'(b0.sram_waddr), wtab[w]);
        chk("lit_bytemask", 0, int'(b0.sram_bytemask), mtab[w]);
        w++;
      end
      if (c <= 6) begin
        chk("lit_raddr_in", 0, int'(b0.sram_raddr_in), ib + rin[c-1]);
        chk("lit_raddr_w", 0, int'(b0.sram_raddr_weight), (wb + c - 1) % 32768);
      end
      chk("lit_busy", 1, int'(b1.busy), int'(c <= 7));
      chk("lit_acc_en", 1, int'(b1.acc_en), int'(c >= 2 && c <= 5));
      chk("lit_acc_clear", 1, int'(b1.acc_clear), int'(c >= 2 && c <= 5));
      chk("lit_out_wen", 1, int'(b1.out_wen), int'(c >= 3 && c <= 6));
      chk("lit_done", 1, int'(b1.done), int'(c == 7));
      b0.start = (c == 3 || c == 15);
      b1.start = (c == 3 || c == 7);
      if (c == 3) begin
        b0.in_base = DAW'(ib + 77); b1.in_base = DAW'(ib + 77);
        b0.weight_base = WAW'(wb + 77); b1.weight_base = WAW'(wb + 77);
      end
    end
    b0.start = 1'b0; b1.start = 1'b0;
  endtask

  task automatic reset_run(input int ib, input int wb);
    b0.start = 1'b1; b1.start = 1'b1;
    b0.in_base = DAW'(ib); b1.in_base = DAW'(ib);
    b0.weight_base = WAW'(wb); b1.weight_base = WAW'(wb);
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      b0.start = 1'b0; b1.start = 1'b0;
    end
    srst = 1'b1;
    @(negedge clk);
    chk("rst_busy", 0, int'(b0.busy), 0);
    chk("rst_acc_en", 0, int'(b0.acc_en), 0);
    chk("rst_out_wen", 0, int'(b0.out_wen), 0);
    chk("rst_raddr_in", 0, int'(b0.sram_raddr_in), 0);
    chk("rst_raddr_w", 0, int'(b0.sram_raddr_weight), 0);
    chk("rst_bytemask", 0, int'(b0.sram_bytemask), 'hF);
    chk("rst_out_wen", 1, int'(b1.out_wen), 0);
    srst = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    srst = 1'b1;
    b0.start = 1'b0; b1.start = 1'b0;
    b0.in_base = '0; b1.in_base = '0;
    b0.weight_base = '0; b1.weight_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("init_busy", 0, int'(b0.busy), 0);
    chk("init_bytemask", 0, int'(b0.sram_bytemask), 'hF);
    chk("init_done", 1, int'(b1.done), 0);
    srst = 1'b0;

    directed_run(5, 100);
    directed_run(200, 7000);
    reset_run(33, 444);
    directed_run(9, 32763);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      srst = ($urandom_range(0, 299) == 0);
      b0.start = ($urandom_range(0, 5) == 0);
      b1.start = ($urandom_range(0, 5) == 0);
      b0.in_base = DAW'($urandom_range(0, 1023));
      b1.in_base = DAW'($urandom_range(0, 1023));
      b0.weight_base = WAW'($urandom_range(0, 32767));
      b1.weight_base = WAW'($urandom_range(0, 32767));
    end
    @(negedge clk);
    srst = 1'b0; b0.start = 1'b0; b1.start = 1'b0;
    repeat (60) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
